// File: rtl/lcd_frame_capture_pkg.sv
// Shared types and default geometry for the DMG LCD pin-bus capture block.
package lcd_capture_pkg;

  localparam int unsigned LCD_W = 160;
  localparam int unsigned LCD_H = 144;

  typedef logic [1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LINE,
    ACTIVE,
    LINE_END
  } cap_state_e;

endpackage

// File: rtl/lcd_frame_capture_pin_sync.sv
// Two-flop synchronizer for the LCD pin bus plus one history register for edge detection.
module lcd_pin_sync #(
  parameter int unsigned W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] pins_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] prev_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pins_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign prev_o = prev_q;

endmodule

// File: rtl/lcd_frame_capture.sv
// Rebuilds a WIDTH x HEIGHT framebuffer write stream from the sampled DMG LCD pins,
// flagging malformed lines, frames and missing FR toggles.
module lcd_frame_capture
  import lcd_capture_pkg::*;
#(
  parameter int unsigned WIDTH  = LCD_W,
  parameter int unsigned HEIGHT = LCD_H,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk2,
  input  logic              reset_video,
  input  logic              pin_cp,
  input  logic              pin_st,
  input  logic              pin_cpl,
  input  logic              pin_s,
  input  logic              pin_fr,
  input  logic [1:0]        pin_ld,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [1:0]        pix_data,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic              fr_err
);

  localparam int unsigned XW = $clog2(WIDTH + 1);
  localparam int unsigned YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]     X_MAX  = XW'(WIDTH);
  localparam logic [YW-1:0]     Y_MAX  = YW'(HEIGHT);
  localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WIDTH);

  // Bus order: {cp, st, cpl, s, fr, ld[1:0]}
  logic [6:0] sync;
  logic [6:0] prev;

  lcd_pin_sync #(.W(7)) u_sync (
    .clk_i  (clk2),
    .rst_i  (reset_video),
    .pins_i ({pin_cp, pin_st, pin_cpl, pin_s, pin_fr, pin_ld}),
    .sync_o (sync),
    .prev_o (prev)
  );

  logic cp_fall, st_rise, cpl_rise, frame_start;
  logic s_fr;
  pix_t s_ld;
  logic unused_prev;

  assign cp_fall     = prev[6] & ~sync[6];
  assign st_rise     = sync[5] & ~prev[5];
  assign cpl_rise    = sync[4] & ~prev[4];
  assign frame_start = cpl_rise & sync[3];
  assign s_fr        = sync[2];
  assign s_ld        = sync[1:0];
  assign unused_prev = ^prev[3:0];

  cap_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  pix_t              data_q, data_d;
  logic              done_q, done_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;
  logic              fr_err_q, fr_err_d;
  logic              fr_seen_q, fr_seen_d;
  logic              fr_last_q, fr_last_d;

  always_ff @(posedge clk2) begin
    if (reset_video) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      fr_err_q    <= 1'b0;
      fr_seen_q   <= 1'b0;
      fr_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      fr_err_q    <= fr_err_d;
      fr_seen_q   <= fr_seen_d;
      fr_last_q   <= fr_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    fr_err_d    = fr_err_q;
    fr_seen_d   = fr_seen_q;
    fr_last_d   = fr_last_q;

    // FR must alternate between successive frame starts; the first one only arms the check.
    if (frame_start) begin
      if (fr_seen_q && (s_fr == fr_last_q)) fr_err_d = 1'b1;
      fr_seen_d = 1'b1;
      fr_last_d = s_fr;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          y_d     = '0;
          base_d  = '0;
          state_d = WAIT_LINE;
        end
      end
      WAIT_LINE: begin
        if (frame_start) begin
          if (y_q != '0) frame_err_d = 1'b1;
          y_d    = '0;
          base_d = '0;
        end else if (st_rise) begin
          x_d     = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // A pixel landing with the latch pulse is written before the line closes.
        if (cp_fall) begin
          if (x_q < X_MAX) begin
            if (y_q < Y_MAX) begin
              we_d   = 1'b1;
              addr_d = base_q + ADDR_W'(x_q);
              data_d = s_ld;
            end else begin
              frame_err_d = 1'b1;
            end
            x_d = x_q + 1'b1;
          end else begin
            line_err_d = 1'b1;
          end
        end
        if (frame_start) begin
          if (y_q != '0) frame_err_d = 1'b1;
          y_d     = '0;
          base_d  = '0;
          state_d = WAIT_LINE;
        end else if (cpl_rise) begin
          state_d = LINE_END;
        end
      end
      LINE_END: begin
        if (x_q != X_MAX) line_err_d = 1'b1;
        y_d    = y_q + 1'b1;
        base_d = base_q + STRIDE;
        if (y_q == Y_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_LINE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix_we     = we_q;
  assign pix_addr   = addr_q;
  assign pix_data   = data_q;
  assign frame_done = done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign fr_err     = fr_err_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture on a reduced 20x16 geometry.
module tb_lcd_frame_capture;

  localparam int unsigned W  = 20;
  localparam int unsigned H  = 16;
  localparam int unsigned AW = 9;

  logic          clk2 = 1'b0;
  logic          reset_video;
  logic          pin_cp, pin_st, pin_cpl, pin_s, pin_fr;
  logic [1:0]    pin_ld;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [1:0]    pix_data;
  logic          frame_done, line_err, frame_err, fr_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned wr_addr[$];
  logic [1:0]  wr_data[$];
  int unsigned done_cnt  = 0;
  int unsigned clash_cnt = 0;

  always #5 clk2 = ~clk2;

  lcd_frame_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk2        (clk2),
    .reset_video (reset_video),
    .pin_cp      (pin_cp),
    .pin_st      (pin_st),
    .pin_cpl     (pin_cpl),
    .pin_s       (pin_s),
    .pin_fr      (pin_fr),
    .pin_ld      (pin_ld),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_err   (frame_err),
    .fr_err      (fr_err)
  );

  always @(negedge clk2) begin
    if (pix_we) begin
      wr_addr.push_back(int'(pix_addr));
      wr_data.push_back(pix_data);
    end
    if (frame_done) done_cnt++;
    if (frame_done && pix_we) clash_cnt++;
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk2);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt  = 0;
    clash_cnt = 0;
  endtask

  task automatic do_reset();
    {pin_cp, pin_st, pin_cpl, pin_s, pin_fr} = '0;
    pin_ld      = '0;
    reset_video = 1'b1;
    cyc(3);
    reset_video = 1'b0;
    cyc(2);
    clear_log();
  endtask

  task automatic pixel(input logic [1:0] ld);
    pin_ld = ld;
    pin_cp = 1'b1;
    cyc(2);
    pin_cp = 1'b0;
    cyc(2);
  endtask

  task automatic st_pulse();
    pin_st = 1'b1;
    cyc(2);
    pin_st = 1'b0;
    cyc(2);
  endtask

  task automatic cpl_pulse(input logic s);
    pin_s   = s;
    pin_cpl = 1'b1;
    cyc(2);
    pin_cpl = 1'b0;
    cyc(2);
    pin_s   = 1'b0;
  endtask

  task automatic frame_start(input logic fr);
    pin_fr = fr;
    cpl_pulse(1'b1);
    cyc(2);
  endtask

  task automatic send_line(input int unsigned y, input int unsigned n);
    st_pulse();
    for (int unsigned x = 0; x < n; x++) pixel(2'((x + y) % 4));
    cpl_pulse(1'b0);
    cyc(3);
  endtask

  task automatic test_reset();
    reset_video = 1'b1;
    {pin_cp, pin_st, pin_cpl, pin_s, pin_fr} = '1;
    pin_ld = 2'b11;
    cyc(4);
    checks++; if (pix_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", pix_we); end
    checks++; if (pix_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", pix_addr); end
    checks++; if (pix_data !== 2'b00) begin errors++; $display("FAIL reset_data: got %0d want 0", pix_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    checks++; if ({line_err, frame_err, fr_err} !== 3'b000) begin
      errors++; $display("FAIL reset_errs: got %b want 000", {line_err, frame_err, fr_err});
    end
    do_reset();
  endtask

  task automatic test_nominal();
    do_reset();
    frame_start(1'b0);
    for (int unsigned y = 0; y < H; y++) send_line(y, W);
    cyc(6);
    checks++; if (wr_addr.size() != W * H) begin
      errors++; $display("FAIL nom_count: got %0d want %0d", wr_addr.size(), W * H);
    end
    for (int unsigned i = 0; i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] != i) begin
        errors++; if (errors < 20) $display("FAIL nom_addr[%0d]: got %0d want %0d", i, wr_addr[i], i);
      end
      checks++; if (wr_data[i] !== 2'(((i / W) + (i % W)) % 4)) begin
        errors++; if (errors < 20) $display("FAIL nom_data[%0d]: got %0d want %0d", i, wr_data[i], ((i / W) + (i % W)) % 4);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL nom_done: got %0d want 1", done_cnt); end
    checks++; if (clash_cnt != 0) begin errors++; $display("FAIL nom_done_we_clash: got %0d want 0", clash_cnt); end
    checks++; if ({line_err, frame_err, fr_err} !== 3'b000) begin
      errors++; $display("FAIL nom_errs: got %b want 000", {line_err, frame_err, fr_err});
    end
  endtask

  task automatic test_short_line();
    do_reset();
    frame_start(1'b1);
    for (int unsigned y = 0; y < 5; y++) send_line(y, W);
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL short_pre: got %b want 0", line_err); end
    send_line(5, W - 1);
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL short_line_err: got %b want 1", line_err); end
    clear_log();
    send_line(6, W);
    checks++; if (wr_addr.size() == 0 || wr_addr[0] != 6 * W) begin
      errors++; $display("FAIL short_next_addr: got %0d want %0d", (wr_addr.size() == 0) ? 0 : wr_addr[0], 6 * W);
    end
  endtask

  task automatic test_long_line();
    int unsigned hit;
    do_reset();
    frame_start(1'b0);
    send_line(0, W + 1);
    hit = 0;
    foreach (wr_addr[i]) if (wr_addr[i] == W) hit++;
    checks++; if (wr_addr.size() != W) begin errors++; $display("FAIL long_count: got %0d want %0d", wr_addr.size(), W); end
    checks++; if (hit != 0) begin errors++; $display("FAIL long_addr_w: got %0d writes want 0", hit); end
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL long_line_err: got %b want 1", line_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL long_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_early_frame();
    do_reset();
    frame_start(1'b0);
    for (int unsigned y = 0; y < 10; y++) send_line(y, W);
    st_pulse();
    for (int unsigned x = 0; x < W; x++) pixel(2'(x % 4));
    cpl_pulse(1'b1);
    cyc(3);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_frame_err: got %b want 1", frame_err); end
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL early_line_err: got %b want 0", line_err); end
    clear_log();
    send_line(0, W);
    cyc(4);
    checks++; if (wr_addr.size() == 0 || wr_addr[0] != 0) begin
      errors++; $display("FAIL early_next_addr: got %0d want 0", (wr_addr.size() == 0) ? 999 : wr_addr[0]);
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL early_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_fr_toggle();
    do_reset();
    frame_start(1'b0);
    checks++; if (fr_err !== 1'b0) begin errors++; $display("FAIL fr_first: got %b want 0", fr_err); end
    frame_start(1'b0);
    checks++; if (fr_err !== 1'b1) begin errors++; $display("FAIL fr_same: got %b want 1", fr_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fr_frame_err: got %b want 0", frame_err); end
    do_reset();
    checks++; if (fr_err !== 1'b0) begin errors++; $display("FAIL fr_reset_clear: got %b want 0", fr_err); end
    frame_start(1'b0);
    frame_start(1'b1);
    checks++; if (fr_err !== 1'b0) begin errors++; $display("FAIL fr_toggled: got %b want 0", fr_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame_start(1'b0);
    st_pulse();
    for (int unsigned x = 0; x < W - 1; x++) pixel(2'(x % 4));
    pin_ld = 2'b11;
    pin_cp = 1'b1;
    cyc(2);
    pin_cp  = 1'b0;
    pin_cpl = 1'b1;
    cyc(2);
    pin_cpl = 1'b0;
    cyc(5);
    checks++; if (wr_addr.size() != W) begin errors++; $display("FAIL b2b_count: got %0d want %0d", wr_addr.size(), W); end
    checks++; if (wr_addr.size() == 0 || wr_addr[wr_addr.size() - 1] != W - 1 || wr_data[wr_data.size() - 1] !== 2'b11) begin
      errors++; $display("FAIL b2b_last_pixel: got size %0d want addr %0d data 3", wr_addr.size(), W - 1);
    end
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL b2b_line_err: got %b want 0", line_err); end
    send_line(1, W);
    checks++; if (wr_addr.size() <= W || wr_addr[W] != W) begin
      errors++; $display("FAIL b2b_next_line: got size %0d want first addr %0d", wr_addr.size(), W);
    end
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    frame_start(1'b0);
    for (int unsigned y = 0; y < 3; y++) send_line(y, W);
    st_pulse();
    for (int unsigned x = 0; x < 10; x++) pixel(2'b01);
    cyc(2);
    reset_video = 1'b1;
    cyc(1);
    checks++; if ({pix_we, pix_addr, pix_data} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got we=%b addr=%0d data=%0d want 0", pix_we, pix_addr, pix_data);
    end
    reset_video = 1'b0;
    cyc(2);
    clear_log();
    st_pulse();
    for (int unsigned x = 0; x < 5; x++) pixel(2'b10);
    cpl_pulse(1'b0);
    cyc(3);
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL mid_reset_ignored: got %0d writes want 0", wr_addr.size()); end
    frame_start(1'b0);
    send_line(0, W);
    checks++; if (wr_addr.size() != W || wr_addr[0] != 0) begin
      errors++; $display("FAIL mid_reset_resume: got %0d writes want %0d from addr 0", wr_addr.size(), W);
    end
    checks++; if (fr_err !== 1'b0) begin errors++; $display("FAIL mid_reset_fr: got %b want 0", fr_err); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_long_line();
    test_early_frame();
    test_fr_toggle();
    test_back_to_back();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
